data_mem_mmio: RTL
==================

Name: data_mem_mmio

Overview:
- Parametrised successor of the single-port data memory with memory-mapped IO.
- Byte-addressed RAM of 2^ADDR_W bytes, accessed as 16-bit little-endian half-words, with per-byte write enables.
- An IO window at IO_BASE maps seven-segment value, LEDs, switches, button levels and sticky button-press flags.
- Sits between the CPU load/store stage and board IO; the seven-segment driver is fed from seg_value.

Parameters:
- ADDR_W, 8, byte address width; RAM depth = 2^ADDR_W bytes.
- IO_BASE, 8'h40, byte address of the IO window. Must be aligned to 32 and lie inside 2^ADDR_W.
- NUM_SW, 16, switch count (≤16).
- NUM_BTN, 5, button count (≤8).

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST_N  in  1  synchronous, active-low reset.
- addr  in  ADDR_W  byte address; low byte at addr, high byte at addr+1.
- rd_en  in  1  read request, sampled each cycle.
- wr_en  in  1  write request, sampled each cycle.
- wr_be  in  2  byte enables: [0] = byte at addr, [1] = byte at addr+1.
- wr_data  in  16  write data.
- rd_data  out  16  read data.
- rd_valid  out  1  one-cycle pulse; rd_data valid while it is high.
- SW  in  NUM_SW  raw switches.
- BTNS  in  NUM_BTN  raw buttons, asynchronous.
- LED  out  16  LED register.
- seg_value  out  32  seven-segment value register.

Behaviour:
- Reset (RST_N=0 at an edge):
  - rd_data=0, rd_valid=0, LED=0, seg_value=0.
  - Button synchronisers and sticky flags cleared.
  - RAM contents are not cleared; RAM is zero at configuration only.
  - A request in the reset cycle is dropped.
- IO map, offsets from IO_BASE:
  - +0..+3: seg_value bytes 0..3, read/write.
  - +4..+5: LED bytes 0..1, read/write.
  - +E..+F: SW low/high byte, read-only, zero-extended.
  - +10: synchronised button level, read-only, zero-extended.
  - +11: sticky press flags, read-only, clear-on-read.
  - All other window offsets behave as plain RAM.
- Byte addressing:
  - Each of the two bytes is decoded independently.
  - addr+1 wraps modulo 2^ADDR_W; addr=all-ones pairs with byte 0.
- Write:
  - Commits on the edge where wr_en=1.
  - Only enabled bytes change.
  - Bytes landing on read-only IO locations are silently ignored; the other byte still commits.
  - Single-cycle, no pulse-edge detection on wr_en.
- Read:
  - Latency 1. rd_en=1 at edge N gives rd_data and rd_valid=1 after edge N.
  - rd_data holds its value when rd_valid=0.
  - Back-to-back reads are allowed every cycle.
- Simultaneous rd_en and wr_en to an overlapping byte: read returns the pre-write value (read-first); the write commits.
- Switches are sampled into the readable register every cycle, so a read reflects SW one to two cycles old.
- Buttons:
  - Each bit goes through a two-flop synchroniser, then rising-edge detect.
  - A rising edge sets that bit's sticky flag.
  - A read accepted on a byte covering +11 returns the flags and clears them at the same edge.
  - An edge arriving in the clearing cycle wins: the flag stays set.
- No stalls: every request completes with fixed latency.

Decomposition:
- Package data_mem_pkg holds:
  - IO offset constants: OFF_SEG=0, OFF_LED=4, OFF_SW_LO=E, OFF_SW_HI=F, OFF_BTN=10, OFF_BTN_EVT=11.
  - An is_read_only(offset) function.
- One sub-module, btn_event_capture (parameter N): synchroniser, edge detect, sticky flags with clear input.
- Byte RAM and address decode stay in the top module.

Test Plan:
- Reset, then write addr=0x10 wr_be=11 wr_data=0xBEEF, then read 0x10 -> one cycle later rd_valid=1, rd_data=0xBEEF; read 0x11 -> rd_data[7:0]=0xBE.
- Write 0x20 data=0x1234 be=11, then write 0x20 data=0xAB00 be=10 -> read 0x20 gives 0xAB34.
- Write IO_BASE+4 data=0x00F0 -> LED=0x00F0 after the edge; write IO_BASE+0 and +2 with 0x5678/0x1234 -> seg_value=0x12345678.
- SW=0xA55A, write 0xFFFF to IO_BASE+E -> write ignored; read IO_BASE+E returns 0xA55A.
- BTNS[2] pulses high then low for 3 cycles -> read IO_BASE+10 (be high byte) returns high byte 0x04; next read returns 0x00. A press edge in the clear cycle -> flag remains 0x04.
- ADDR_W=8: write addr=0xFF data=0xCDEF -> mem[0xFF]=0xEF, mem[0x00]=0xCD. Read+write same addr same cycle -> old data returned. RST_N=0 mid-read -> rd_valid=0, LED=0.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared constants for the data memory: IO window offsets and helpers to classify them.
package data_mem_pkg;

  localparam logic [4:0] OFF_SEG     = 5'h00;
  localparam logic [4:0] OFF_LED     = 5'h04;
  localparam logic [4:0] OFF_SW_LO   = 5'h0E;
  localparam logic [4:0] OFF_SW_HI   = 5'h0F;
  localparam logic [4:0] OFF_BTN     = 5'h10;
  localparam logic [4:0] OFF_BTN_EVT = 5'h11;

  function automatic logic is_read_only(input logic [4:0] off);
    return (off == OFF_SW_LO) || (off == OFF_SW_HI) ||
           (off == OFF_BTN)   || (off == OFF_BTN_EVT);
  endfunction

  // Any window offset that is backed by a register rather than RAM.
  function automatic logic is_io_reg(input logic [4:0] off);
    return (off[4:2] == OFF_SEG[4:2]) || (off[4:1] == OFF_LED[4:1]) ||
           is_read_only(off);
  endfunction

endpackage

// File: rtl/btn_event_capture.sv
// Button synchroniser with rising-edge detect and sticky press flags.
module btn_event_capture #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] btn,
  input  logic         clr,
  output logic [N-1:0] level,
  output logic [N-1:0] flags
);

  logic [N-1:0] sync1;
  logic [N-1:0] sync2;
  logic [N-1:0] prev;
  logic [N-1:0] rise;

  assign rise  = sync2 & ~prev;
  assign level = sync2;

  // A rising edge in the same cycle as a clear keeps its flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      flags <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
      flags <= (flags & ~{N{clr}}) | rise;
    end
  end

endmodule

// File: rtl/data_mem_mmio.sv
// Byte-addressed half-word data memory with a memory-mapped IO window for board peripherals.
module data_mem_mmio
  import data_mem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int IO_BASE = 'h40,
  parameter int NUM_SW  = 16,
  parameter int NUM_BTN = 5
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [ADDR_W-1:0]  addr,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [1:0]         wr_be,
  input  logic [15:0]        wr_data,
  output logic [15:0]        rd_data,
  output logic               rd_valid,
  input  logic [NUM_SW-1:0]  SW,
  input  logic [NUM_BTN-1:0] BTNS,
  output logic [15:0]        LED,
  output logic [31:0]        seg_value
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(IO_BASE);

  logic [7:0] mem [DEPTH] = '{default: 8'h00};

  logic [1:0][ADDR_W-1:0] lane_addr;
  logic [1:0]             lane_io;
  logic [1:0][4:0]        lane_off;
  logic [1:0][7:0]        lane_rd;
  logic [NUM_SW-1:0]      sw_q;
  logic [15:0]            sw_ext;
  logic [NUM_BTN-1:0]     btn_level;
  logic [NUM_BTN-1:0]     btn_flags;
  logic                   evt_clr;

  assign sw_ext = 16'(sw_q);

  btn_event_capture #(.N(NUM_BTN)) u_btn (
    .clk   (CLK),
    .rst_n (RST_N),
    .btn   (BTNS),
    .clr   (evt_clr),
    .level (btn_level),
    .flags (btn_flags)
  );

  // Each byte lane is decoded on its own; the upper lane wraps around the address space.
  always_comb begin
    lane_addr[0] = addr;
    lane_addr[1] = addr + ADDR_W'(1);
    evt_clr      = 1'b0;
    for (int i = 0; i < 2; i++) begin
      lane_io[i]  = (lane_addr[i][ADDR_W-1:5] == BASE[ADDR_W-1:5]);
      lane_off[i] = lane_addr[i][4:0];
      lane_rd[i]  = mem[lane_addr[i]];
      if (lane_io[i]) begin
        if (lane_off[i][4:2] == OFF_SEG[4:2])
          lane_rd[i] = seg_value[{lane_off[i][1:0], 3'b000} +: 8];
        else if (lane_off[i][4:1] == OFF_LED[4:1])
          lane_rd[i] = LED[{lane_off[i][0], 3'b000} +: 8];
        else if (lane_off[i] == OFF_SW_LO)
          lane_rd[i] = sw_ext[7:0];
        else if (lane_off[i] == OFF_SW_HI)
          lane_rd[i] = sw_ext[15:8];
        else if (lane_off[i] == OFF_BTN)
          lane_rd[i] = 8'(btn_level);
        else if (lane_off[i] == OFF_BTN_EVT) begin
          lane_rd[i] = 8'(btn_flags);
          evt_clr    = rd_en;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    sw_q <= SW;
  end

  // Register-backed locations never touch RAM; read-only ones simply drop the write.
  always_ff @(posedge CLK) begin
    if (RST_N && wr_en) begin
      for (int i = 0; i < 2; i++) begin
        if (wr_be[i] && !(lane_io[i] && is_io_reg(lane_off[i])))
          mem[lane_addr[i]] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      LED       <= '0;
      seg_value <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < 2; i++) begin
        if (wr_be[i] && lane_io[i]) begin
          if (lane_off[i][4:2] == OFF_SEG[4:2])
            seg_value[{lane_off[i][1:0], 3'b000} +: 8] <= wr_data[8*i +: 8];
          else if (lane_off[i][4:1] == OFF_LED[4:1])
            LED[{lane_off[i][0], 3'b000} +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Read data is captured before any same-edge write lands, giving read-first behaviour.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en)
        rd_data <= {lane_rd[1], lane_rd[0]};
    end
  end

endmodule
